// File: rtl/pipe_stage_regs_if.sv
// Bundle between the hazard/fetch logic and the pipeline stage registers:
// PC source, IF/ID/EX/MEM/WB hold/flush controls, stage contents and perf counters.
interface pipe_stage_regs_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      pc_next;
  logic [31:0]      instr_F;
  logic             valid_F;
  logic             pc_enable;
  logic             IF_ID_enable, IF_ID_flush;
  logic             ID_EX_enable, ID_EX_flush;
  logic             EX_ME_enable, EX_ME_flush;
  logic             ME_WB_enable, ME_WB_flush;

  logic [31:0]      pc_F;
  logic [31:0]      pc_D, instr_D;
  logic             valid_D;
  logic [31:0]      pc_E, instr_E;
  logic             valid_E;
  logic [31:0]      pc_M, instr_M;
  logic             valid_M;
  logic [31:0]      pc_W, instr_W;
  logic             valid_W;
  logic [CNT_W-1:0] retire_cnt, flush_cnt, stall_cnt;

  modport master (
    output pc_next, instr_F, valid_F, pc_enable,
           IF_ID_enable, IF_ID_flush, ID_EX_enable, ID_EX_flush,
           EX_ME_enable, EX_ME_flush, ME_WB_enable, ME_WB_flush,
    input  pc_F, pc_D, instr_D, valid_D, pc_E, instr_E, valid_E,
           pc_M, instr_M, valid_M, pc_W, instr_W, valid_W,
           retire_cnt, flush_cnt, stall_cnt
  );

  modport slave (
    input  pc_next, instr_F, valid_F, pc_enable,
           IF_ID_enable, IF_ID_flush, ID_EX_enable, ID_EX_flush,
           EX_ME_enable, EX_ME_flush, ME_WB_enable, ME_WB_flush,
    output pc_F, pc_D, instr_D, valid_D, pc_E, instr_E, valid_E,
           pc_M, instr_M, valid_M, pc_W, instr_W, valid_W,
           retire_cnt, flush_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// PC register, the four RV32I pipeline stage registers with hold/flush control,
// and saturating retire/flush/stall performance counters.

// One pipeline stage register; flush outranks enable so a bubble is inserted
// even when the hazard unit also deasserts enable.
module pipe_stage_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        flush,
  input  logic [31:0] pc_up,
  input  logic [31:0] instr_up,
  input  logic        valid_up,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      pc    <= 32'h0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (enable) begin
      pc    <= pc_up;
      instr <= instr_up;
      valid <= valid_up;
    end
  end
endmodule

module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && !(&cnt))
      cnt <= cnt + 1'b1;
  end
endmodule

module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic clk,
  input  logic rst_n,
  pipe_stage_regs_if.slave bus
);
  localparam int STAGES = 4;

  logic [31:0] pc_F;

  always_ff @(posedge clk) begin
    if (!rst_n)
      pc_F <= RESET_PC;
    else if (bus.pc_enable)
      pc_F <= bus.pc_next;
  end

  // Index 0..3 = D, E, M, W; each stage's upstream is the previous index (F for D).
  logic [STAGES-1:0]       en, fl;
  logic [STAGES-1:0][31:0] up_pc, up_instr, st_pc, st_instr;
  logic [STAGES-1:0]       up_valid, st_valid;

  assign en = {bus.ME_WB_enable, bus.EX_ME_enable, bus.ID_EX_enable, bus.IF_ID_enable};
  assign fl = {bus.ME_WB_flush,  bus.EX_ME_flush,  bus.ID_EX_flush,  bus.IF_ID_flush};

  assign up_pc    = {st_pc[STAGES-2:0],    pc_F};
  assign up_instr = {st_instr[STAGES-2:0], bus.instr_F};
  assign up_valid = {st_valid[STAGES-2:0], bus.valid_F};

  pipe_stage_reg #(.NOP_INSTR(NOP_INSTR)) u_stage [STAGES-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (en),
    .flush    (fl),
    .pc_up    (up_pc),
    .instr_up (up_instr),
    .valid_up (up_valid),
    .pc       (st_pc),
    .instr    (st_instr),
    .valid    (st_valid)
  );

  assign bus.pc_F    = pc_F;
  assign bus.pc_D    = st_pc[0];
  assign bus.instr_D = st_instr[0];
  assign bus.valid_D = st_valid[0];
  assign bus.pc_E    = st_pc[1];
  assign bus.instr_E = st_instr[1];
  assign bus.valid_E = st_valid[1];
  assign bus.pc_M    = st_pc[2];
  assign bus.instr_M = st_instr[2];
  assign bus.valid_M = st_valid[2];
  assign bus.pc_W    = st_pc[3];
  assign bus.instr_W = st_instr[3];
  assign bus.valid_W = st_valid[3];

  // Counter lanes: 0 = retire (W leaves the stage), 1 = redirect, 2 = fetch stall.
  logic [2:0]            inc;
  logic [2:0][CNT_W-1:0] cnt;

  assign inc[0] = st_valid[3] & (bus.ME_WB_enable | bus.ME_WB_flush);
  assign inc[1] = bus.IF_ID_flush;
  assign inc[2] = ~bus.pc_enable;

  pipe_sat_cnt #(.W(CNT_W)) u_cnt [2:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .cnt   (cnt)
  );

  assign bus.retire_cnt = cnt[0];
  assign bus.flush_cnt  = cnt[1];
  assign bus.stall_cnt  = cnt[2];
endmodule
